// File: rtl/etroc_fc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : etroc_fc_sequencer
//  Purpose  : Plays back a table of 4-bit fast-command codes (finite or
//             infinite passes), merges a delayed, dead-time-filtered external
//             L1A trigger, applies hold-L1A filtering and one-shot error
//             injection, and emits one encoded 8-bit command per clk40 cycle.
//  Revision : 1.0  initial release
// ============================================================================
module etroc_fc_sequencer #(
    parameter int ADDR_W    = 12,
    parameter int DLY_DEPTH = 1024,
    parameter int DLY_W     = 10,
    parameter int LOOP_W    = 16
) (
    input  logic              clk40,
    input  logic              rstn,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [3:0]        wr_cmd_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    input  logic [LOOP_W-1:0] loop_count_i,
    input  logic              ext_trig_i,
    input  logic              en_trig_i,
    input  logic [DLY_W-1:0]  trig_delay_i,
    input  logic [7:0]        holdoff_i,
    input  logic              hold_l1a_i,
    input  logic [7:0]        err_mask_i,
    input  logic              err_inj_i,
    output logic [7:0]        cmd_out_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       trig_dropped_o
);

    localparam logic [7:0]       C_IDLE    = 8'hF0;
    localparam logic [7:0]       C_L1A     = 8'h96;
    localparam logic [7:0]       C_L1A_BCR = 8'h99;
    localparam logic [7:0]       C_BCR     = 8'h5A;
    localparam logic [DLY_W:0]   C_DEPTH   = (DLY_W+1)'(DLY_DEPTH);
    localparam logic [DLY_W-1:0] C_TAP_MAX = DLY_W'(DLY_DEPTH - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    function automatic logic [7:0] encode(input logic [3:0] code);
        case (code)
            4'd1:    encode = 8'h33;
            4'd2:    encode = 8'h5A;
            4'd3:    encode = 8'h55;
            4'd4:    encode = 8'h66;
            4'd5:    encode = 8'h69;
            4'd6:    encode = 8'h96;
            4'd7:    encode = 8'h99;
            4'd8:    encode = 8'hA5;
            4'd9:    encode = 8'hAA;
            default: encode = C_IDLE;
        endcase
    endfunction

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   last_q;
    logic [LOOP_W-1:0]   loop_q;
    logic [LOOP_W-1:0]   passes_q;
    logic                busy_q;
    logic                done_q;
    logic                valid_q;
    logic [3:0]          rd_cmd_q;
    logic [3:0]          table_q [0:(2**ADDR_W)-1];
    logic [DLY_DEPTH-1:0] dly_q;
    logic [7:0]          ho_q;
    logic [15:0]         dropped_q;
    logic [7:0]          cmd_q;

    logic                wrap;
    logic                last_pass;
    logic                run_d;
    logic [ADDR_W-1:0]   rd_addr_d;
    logic [DLY_W-1:0]    tap_d;
    logic                dtrig;
    logic                trig_acc;
    logic                trig_drop;
    logic [7:0]          cmd_d;

    // Lookahead of the FSM: the table is read with the address the FSM
    // will hold next cycle, so each entry lands on cmd_out two cycles after
    // that address is issued.
    assign wrap      = (addr_q == last_q);
    assign last_pass = wrap && (loop_q != '0) &&
                       (LOOP_W'(passes_q + 1'b1) == loop_q);
    assign run_d     = (state_q == S_IDLE) ? (start_i & ~stop_i)
                                           : ~(stop_i | last_pass);
    assign rd_addr_d = (state_q == S_RUN && !wrap) ? ADDR_W'(addr_q + 1'b1)
                                                   : '0;

    // Trigger tap selection with clamp to the physical delay-line length.
    assign tap_d     = ({1'b0, trig_delay_i} >= C_DEPTH) ? C_TAP_MAX : trig_delay_i;
    assign dtrig     = dly_q[tap_d];
    assign trig_acc  = dtrig & en_trig_i & (ho_q == 8'd0);
    assign trig_drop = dtrig & en_trig_i & (ho_q != 8'd0);

    // Command table: no reset, read-first synchronous read.
    always_ff @(posedge clk40) begin
        if (wr_en_i) begin
            table_q[wr_addr_i] <= wr_cmd_i;
        end
        rd_cmd_q <= table_q[rd_addr_d];
    end

    // Playback FSM: latches pass parameters, walks addresses, counts passes.
    always_ff @(posedge clk40) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            last_q   <= '0;
            loop_q   <= '0;
            passes_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= run_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !stop_i) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        addr_q   <= '0;
                        passes_q <= '0;
                        last_q   <= last_addr_i;
                        loop_q   <= loop_count_i;
                    end
                end
                S_RUN: begin
                    if (stop_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (wrap) begin
                        addr_q <= '0;
                        if (last_pass) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            passes_q <= LOOP_W'(passes_q + 1'b1);
                        end
                    end else begin
                        addr_q <= ADDR_W'(addr_q + 1'b1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Trigger delay line, holdoff dead-time counter and drop counter.
    always_ff @(posedge clk40) begin
        if (!rstn) begin
            dly_q     <= '0;
            ho_q      <= 8'd0;
            dropped_q <= 16'd0;
        end else begin
            dly_q <= {dly_q[DLY_DEPTH-2:0], ext_trig_i};
            if (trig_acc) begin
                ho_q <= holdoff_i;
            end else if (ho_q != 8'd0) begin
                ho_q <= ho_q - 8'd1;
            end
            if (trig_drop && dropped_q != 16'hFFFF) begin
                dropped_q <= dropped_q + 16'd1;
            end
        end
    end

    // Output merge: trigger override, then hold-L1A filter, then error XOR.
    always_comb begin
        cmd_d = valid_q ? encode(rd_cmd_q) : C_IDLE;
        if (trig_acc) begin
            cmd_d = C_L1A;
        end
        if (hold_l1a_i) begin
            if (cmd_d == C_L1A) begin
                cmd_d = C_IDLE;
            end else if (cmd_d == C_L1A_BCR) begin
                cmd_d = C_BCR;
            end
        end
        if (err_inj_i) begin
            cmd_d = cmd_d ^ err_mask_i;
        end
    end

    // Registered fast-command output.
    always_ff @(posedge clk40) begin
        if (!rstn) begin
            cmd_q <= C_IDLE;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign cmd_out_o      = cmd_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign trig_dropped_o = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_etroc_fc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_etroc_fc_sequencer
//  Purpose  : Directed self-checking bench for etroc_fc_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_etroc_fc_sequencer;

    localparam int ADDR_W    = 12;
    localparam int DLY_DEPTH = 1024;
    localparam int DLY_W     = 10;
    localparam int LOOP_W    = 16;

    logic              clk40 = 1'b0;
    logic              rstn;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_cmd;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] last_addr;
    logic [LOOP_W-1:0] loop_count;
    logic              ext_trig;
    logic              en_trig;
    logic [DLY_W-1:0]  trig_delay;
    logic [7:0]        holdoff;
    logic              hold_l1a;
    logic [7:0]        err_mask;
    logic              err_inj;
    logic [7:0]        cmd_out;
    logic              busy;
    logic              done;
    logic [15:0]       trig_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] code;
        logic       hold;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [19];
    logic [7:0] pat  [4];
    logic [7:0] pat6 [4];

    etroc_fc_sequencer #(
        .ADDR_W   (ADDR_W),
        .DLY_DEPTH(DLY_DEPTH),
        .DLY_W    (DLY_W),
        .LOOP_W   (LOOP_W)
    ) dut (
        .clk40         (clk40),
        .rstn          (rstn),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_cmd_i      (wr_cmd),
        .start_i       (start),
        .stop_i        (stop),
        .last_addr_i   (last_addr),
        .loop_count_i  (loop_count),
        .ext_trig_i    (ext_trig),
        .en_trig_i     (en_trig),
        .trig_delay_i  (trig_delay),
        .holdoff_i     (holdoff),
        .hold_l1a_i    (hold_l1a),
        .err_mask_i    (err_mask),
        .err_inj_i     (err_inj),
        .cmd_out_o     (cmd_out),
        .busy_o        (busy),
        .done_o        (done),
        .trig_dropped_o(trig_dropped)
    );

    always #5 clk40 = ~clk40;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk40);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [3:0] c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_cmd  = c;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_cmd = '0;
        start = 1'b0; stop = 1'b0; last_addr = '0; loop_count = '0;
        ext_trig = 1'b0; en_trig = 1'b0; trig_delay = '0; holdoff = '0;
        hold_l1a = 1'b0; err_mask = '0; err_inj = 1'b0;

        pat  = '{8'h5A, 8'h96, 8'hF0, 8'h69};
        pat6 = '{8'h96, 8'h99, 8'hF0, 8'h69};

        vecs[0]  = '{4'd0,  1'b0, 8'hF0};
        vecs[1]  = '{4'd1,  1'b0, 8'h33};
        vecs[2]  = '{4'd2,  1'b0, 8'h5A};
        vecs[3]  = '{4'd3,  1'b0, 8'h55};
        vecs[4]  = '{4'd4,  1'b0, 8'h66};
        vecs[5]  = '{4'd5,  1'b0, 8'h69};
        vecs[6]  = '{4'd6,  1'b0, 8'h96};
        vecs[7]  = '{4'd7,  1'b0, 8'h99};
        vecs[8]  = '{4'd8,  1'b0, 8'hA5};
        vecs[9]  = '{4'd9,  1'b0, 8'hAA};
        vecs[10] = '{4'd10, 1'b0, 8'hF0};
        vecs[11] = '{4'd11, 1'b0, 8'hF0};
        vecs[12] = '{4'd12, 1'b0, 8'hF0};
        vecs[13] = '{4'd13, 1'b0, 8'hF0};
        vecs[14] = '{4'd14, 1'b0, 8'hF0};
        vecs[15] = '{4'd15, 1'b0, 8'hF0};
        vecs[16] = '{4'd6,  1'b1, 8'hF0};
        vecs[17] = '{4'd7,  1'b1, 8'h5A};
        vecs[18] = '{4'd2,  1'b1, 8'h5A};

        // Reset values
        tick(); tick();
        chk("reset_cmd", cmd_out, 8'hF0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_dropped", trig_dropped, 16'd0);
        rstn = 1'b1;
        tick();

        // Encoding table: single-entry single-pass runs
        for (int v = 0; v < 19; v++) begin
            wr('0, vecs[v].code);
            hold_l1a = vecs[v].hold; last_addr = '0; loop_count = 16'd1;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk($sformatf("vec%0d_busy", v), busy, 1'b1);
            tick();
            chk($sformatf("vec%0d_cmd", v), cmd_out, vecs[v].exp);
            chk($sformatf("vec%0d_done", v), done, 1'b1);
            tick();
            chk($sformatf("vec%0d_busy_end", v), busy, 1'b0);
            chk($sformatf("vec%0d_cmd_end", v), cmd_out, 8'hF0);
            hold_l1a = 1'b0;
        end

        // Two-pass playback of {2,6,0,5}
        wr(12'd0, 4'd2); wr(12'd1, 4'd6); wr(12'd2, 4'd0); wr(12'd3, 4'd5);
        last_addr = 12'd3; loop_count = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("p2_busy_start", busy, 1'b1);
        chk("p2_cmd_first", cmd_out, 8'hF0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("p2_cmd%0d", i), cmd_out, pat[i % 4]);
            chk($sformatf("p2_busy%0d", i), busy, (i < 7) ? 1'b1 : 1'b0);
            chk($sformatf("p2_done%0d", i), done, (i == 7) ? 1'b1 : 1'b0);
        end
        tick();
        chk("p2_done_after", done, 1'b0);
        chk("p2_cmd_after", cmd_out, 8'hF0);

        // Infinite loop, stopped after 10 cycles
        loop_count = 16'd0; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (c >= 2) chk($sformatf("inf_cmd%0d", c), cmd_out, pat[(c - 2) % 4]);
            chk($sformatf("inf_busy%0d", c), busy, 1'b1);
            chk($sformatf("inf_done%0d", c), done, 1'b0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 1'b0);
        chk("stop_cmd_pipe", cmd_out, 8'h96);
        chk("stop_done", done, 1'b0);
        tick();
        chk("stop_cmd_idle1", cmd_out, 8'hF0);
        chk("stop_done2", done, 1'b0);
        tick();
        chk("stop_cmd_idle2", cmd_out, 8'hF0);

        // Start and stop together in IDLE: stays idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 1'b0);
        tick();
        chk("startstop_cmd", cmd_out, 8'hF0);

        // Delayed trigger overriding a table F0 slot
        en_trig = 1'b1; trig_delay = 10'd5; holdoff = 8'd0;
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = 1'b0;
            ext_trig = (c == 5);
            if (c >= 2)
                chk($sformatf("trig_cmd%0d", c), cmd_out,
                    (c == 12) ? 8'h96 : pat[(c - 2) % 4]);
        end
        ext_trig = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(); tick();
        chk("trig_dropped_zero", trig_dropped, 16'd0);

        // Trigger with en_trig=0 is ignored
        en_trig = 1'b0; holdoff = 8'd4; ext_trig = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            ext_trig = 1'b0;
            chk($sformatf("noen_cmd%0d", c), cmd_out, 8'hF0);
        end
        chk("noen_dropped", trig_dropped, 16'd0);

        // Holdoff=4, triggers at T, T+2, T+5
        en_trig = 1'b1;
        for (int c = 0; c < 15; c++) begin
            ext_trig = (c == 0 || c == 2 || c == 5);
            tick();
            chk($sformatf("ho_cmd%0d", c + 1), cmd_out,
                (c + 1 == 7 || c + 1 == 12) ? 8'h96 : 8'hF0);
        end
        ext_trig = 1'b0;
        chk("ho_dropped", trig_dropped, 16'd1);
        en_trig = 1'b0;

        // hold_l1a with table {6,7}, then one error-injected BCR
        wr(12'd0, 4'd6); wr(12'd1, 4'd7);
        hold_l1a = 1'b1; last_addr = 12'd1; loop_count = 16'd0; err_mask = 8'h01;
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start = 1'b0;
            if (c >= 2)
                chk($sformatf("hold_cmd%0d", c), cmd_out,
                    (c == 5) ? 8'h5B : ((c % 2 == 0) ? 8'hF0 : 8'h5A));
            err_inj = (c == 4);
        end
        err_inj = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(); tick();
        hold_l1a = 1'b0;

        // Reset mid-RUN, then replay the unchanged table {6,7,0,5}
        last_addr = 12'd3; loop_count = 16'd0; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
            if (c >= 2) chk($sformatf("mrst_cmd%0d", c), cmd_out, pat6[(c - 2) % 4]);
        end
        rstn = 1'b0;
        tick();
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_cmd", cmd_out, 8'hF0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_dropped", trig_dropped, 16'd0);
        rstn = 1'b1; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
            if (c == 1) chk("replay_busy", busy, 1'b1);
            if (c >= 2) chk($sformatf("replay_cmd%0d", c), cmd_out, pat6[(c - 2) % 4]);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
